// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops the FIFO on credit and presents words as a valid/ready stream.
// Optional delivered-word counter on rd_word_cnt, enabled by defining FIFO_RD_CNT_EN.
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]       rd_word_cnt
`endif
);

    localparam int BUF_D = RD_LAT + 2;
    localparam int PTR_W = $clog2(BUF_D);
    localparam int OCC_W = $clog2(BUF_D + 1);

    logic [OCC_W-1:0]  occ;
    logic              infl;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [DATA_W-1:0] mem [BUF_D];
    logic [OCC_W:0]    credit;
    logic              capture;
    logic              xfer;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts both buffered and in-flight words, so a popped word always has a slot.
    assign credit     = {1'b0, occ} + {{OCC_W{1'b0}}, infl};
    assign fifo_rd_en = !rd_rst && !fifo_empty && (credit < (OCC_W + 1)'(BUF_D));
    assign capture    = (RD_LAT == 0) ? fifo_rd_en : infl;
    assign xfer       = m_valid && m_ready;

    assign m_valid = (occ != '0);
    assign m_data  = m_valid ? mem[head] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            occ  <= '0;
            infl <= 1'b0;
            head <= '0;
            tail <= '0;
        end else begin
            infl <= (RD_LAT == 1) ? fifo_rd_en : 1'b0;
            occ  <= occ + OCC_W'(capture) - OCC_W'(xfer);
            if (capture) tail <= next_ptr(tail);
            if (xfer)    head <= next_ptr(head);
        end
    end

    // NOTE: the storage array has no reset; occ gates m_valid/m_data so stale entries are never visible.
    always_ff @(posedge rd_clk) begin
        if (capture) mem[tail] <= fifo_rd_data;
    end

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)    rd_word_cnt <= '0;
        else if (xfer) rd_word_cnt <= rd_word_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and random checks of fifo_rd_stream with RD_LAT=0 (dut0) and RD_LAT=1 (dut1).
// A behavioural FIFO per DUT feeds words; a scoreboard per DUT tracks popped-but-undelivered words.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rd_rst;
    logic       fe0, fe1, re0, re1, mv0, mv1, mr0, mr1;
    logic [7:0] rdat0, rdat1, md0, md1;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] cnt0_dut, cnt1_dut;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_W(8), .RD_LAT(0)) dut0 (
        .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(fe0), .fifo_rd_en(re0),
        .fifo_rd_data(rdat0), .m_valid(mv0), .m_ready(mr0), .m_data(md0)
`ifdef FIFO_RD_CNT_EN
        , .rd_word_cnt(cnt0_dut)
`endif
    );

    fifo_rd_stream #(.DATA_W(8), .RD_LAT(1)) dut1 (
        .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(fe1), .fifo_rd_en(re1),
        .fifo_rd_data(rdat1), .m_valid(mv1), .m_ready(mr1), .m_data(md1)
`ifdef FIFO_RD_CNT_EN
        , .rd_word_cnt(cnt1_dut)
`endif
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         del0    = 0;
    int         del1    = 0;
    logic [15:0] mcnt0  = '0;
    logic [15:0] mcnt1  = '0;
    bit         rdy, force_empty;
    bit         p0, p1, x0, x1;
    logic [7:0] xd0, xd1, lat1_data;
    logic [7:0] src0[$], src1[$], exp0[$], exp1[$];

    // One clock cycle: drive at negedge, observe, let the edge happen, update the FIFO models.
    task automatic tick();
        logic [7:0] e;
        fe0   = force_empty || (src0.size() == 0);
        rdat0 = (src0.size() != 0) ? src0[0] : 8'h00;
        fe1   = force_empty || (src1.size() == 0);
        rdat1 = lat1_data;
        mr0   = rdy;
        mr1   = rdy;
        #1;
        p0 = re0; p1 = re1;
        x0 = mv0 && mr0; x1 = mv1 && mr1;
        xd0 = md0; xd1 = md1;
        if (x0) begin
            e = (exp0.size() != 0) ? exp0[0] : 8'hxx;
            n_tests++;
            if (exp0.size() == 0 || md0 !== e) begin
                n_fail++;
                $display("FAIL sb0 cyc %0d: m_data=%h expected=%h", cyc, md0, e);
            end
            if (exp0.size() != 0) void'(exp0.pop_front());
            del0++; mcnt0++;
        end
        if (x1) begin
            e = (exp1.size() != 0) ? exp1[0] : 8'hxx;
            n_tests++;
            if (exp1.size() == 0 || md1 !== e) begin
                n_fail++;
                $display("FAIL sb1 cyc %0d: m_data=%h expected=%h", cyc, md1, e);
            end
            if (exp1.size() != 0) void'(exp1.pop_front());
            del1++; mcnt1++;
        end
        @(posedge clk);
        if (p0) begin
            n_tests++;
            if (fe0) begin
                n_fail++;
                $display("FAIL pop_while_empty0 cyc %0d: fifo_rd_en=1 expected=0", cyc);
            end else exp0.push_back(src0.pop_front());
        end
        if (p1) begin
            n_tests++;
            if (fe1) begin
                n_fail++;
                $display("FAIL pop_while_empty1 cyc %0d: fifo_rd_en=1 expected=0", cyc);
            end else begin
                lat1_data = src1.pop_front();
                exp1.push_back(lat1_data);
            end
        end
        n_tests++;
        if (exp0.size() > 2 || exp1.size() > 3) begin
            n_fail++;
            $display("FAIL occ_bound cyc %0d: pending0=%0d pending1=%0d limit 2/3",
                     cyc, exp0.size(), exp1.size());
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        // Power-on reset state, with the FIFO claiming data so fifo_rd_en gating is exercised.
        fe1 = 1'b0; fe0 = 1'b0;
        #1;
        n_tests++;
        if (re1 !== 1'b0 || mv1 !== 1'b0 || md1 !== 8'h00 || re0 !== 1'b0 || mv0 !== 1'b0) begin
            n_fail++;
            $display("FAIL por_state: rd_en1=%b valid1=%b data1=%h rd_en0=%b valid0=%b expected 0/0/00/0/0",
                     re1, mv1, md1, re0, mv0);
        end
`ifdef FIFO_RD_CNT_EN
        n_tests++;
        if (cnt1_dut !== 16'h0000) begin
            n_fail++;
            $display("FAIL por_cnt: rd_word_cnt=%h expected=0000", cnt1_dut);
        end
`endif
        @(negedge clk);
        rd_rst = 1'b0;
        src1 = {8'hA1, 8'hA2};
        rdy = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (mv1 !== 1'b1 || md1 !== 8'hA1 || exp1.size() != 2) begin
            n_fail++;
            $display("FAIL pre_reset_fill: valid=%b data=%h pending=%0d expected 1/a1/2", mv1, md1, exp1.size());
        end
        src1.push_back(8'hA3);
        fe1 = 1'b0;
        #1;
        n_tests++;
        if (re1 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_rd_en: fifo_rd_en=%b expected=1", re1);
        end
        #2 rd_rst = 1'b1;
        #1;
        n_tests++;
        if (mv1 !== 1'b0 || md1 !== 8'h00 || re1 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h rd_en=%b expected 0/00/0", mv1, md1, re1);
        end
        exp0.delete(); exp1.delete();
        mcnt0 = '0; mcnt1 = '0;
        @(negedge clk);
        rd_rst = 1'b0;
        #1;
        n_tests++;
        if (re1 !== 1'b1 || mv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: rd_en=%b valid=%b expected 1/0", re1, mv1);
        end
        begin
            int d;
            d = del1;
            rdy = 1'b1;
            repeat (5) tick();
            n_tests++;
            if (del1 - d != 1 || exp1.size() != 0 || mv1 !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_drain: delivered=%0d pending=%0d valid=%b expected 1/0/0",
                         del1 - d, exp1.size(), mv1);
            end
        end
    endtask

    task automatic test_streaming();
        int first_pop, k;
        first_pop = -1; k = 0;
        for (int i = 1; i <= 16; i++) src1.push_back(8'(i));
        rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (p1 && first_pop < 0) first_pop = cyc - 1;
            if (x1) begin
                n_tests++;
                if ((cyc - 1) != first_pop + 2 + k || xd1 !== 8'(k + 1)) begin
                    n_fail++;
                    $display("FAIL stream_word%0d: cycle=%0d data=%h expected cycle=%0d data=%h",
                             k, cyc - 1, xd1, first_pop + 2 + k, 8'(k + 1));
                end
                k++;
            end
        end
        n_tests++;
        if (k != 16 || mv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: words=%0d valid=%b expected 16/0", k, mv1);
        end
    endtask

    task automatic test_backpressure();
        int pops, d;
        pops = 0; d = del1;
        for (int i = 0; i < 8; i++) src1.push_back(8'h20 + 8'(i));
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p1) pops++;
            if (mv1) begin
                n_tests++;
                if (md1 !== 8'h20) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc %0d: m_data=%h expected=20", cyc, md1);
                end
            end
        end
        n_tests++;
        if (pops != 3 || mv1 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pops: pops=%0d valid=%b expected 3/1", pops, mv1);
        end
        rdy = 1'b1;
        repeat (20) tick();
        n_tests++;
        if (del1 - d != 8 || exp1.size() != 0 || src1.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: delivered=%0d pending=%0d left=%0d expected 8/0/0",
                     del1 - d, exp1.size(), src1.size());
        end
    endtask

    task automatic test_boundary();
        int rd_cnt, d;
        bit seen;
        rd_cnt = 0; d = del1; seen = 1'b0;
        src1.push_back(8'h55);
        rdy = 1'b1;
        repeat (8) begin
            tick();
            if (p1) rd_cnt++;
            if (x1 && xd1 === 8'h55) seen = 1'b1;
        end
        n_tests++;
        if (rd_cnt != 1 || del1 - d != 1 || !seen || mv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary: pops=%0d delivered=%0d seen55=%b valid=%b expected 1/1/1/0",
                     rd_cnt, del1 - d, seen, mv1);
        end
    endtask

    task automatic test_lat0();
        int pop_c, x_c;
        pop_c = -1; x_c = -1;
        src0.push_back(8'hA5);
        rdy = 1'b1;
        repeat (5) begin
            tick();
            if (p0 && pop_c < 0) pop_c = cyc - 1;
            if (x0 && x_c < 0) begin
                x_c = cyc - 1;
                n_tests++;
                if (xd0 !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL lat0_data: m_data=%h expected=a5", xd0);
                end
            end
        end
        n_tests++;
        if (pop_c < 0 || x_c != pop_c + 1) begin
            n_fail++;
            $display("FAIL lat0_latency: pop cycle=%0d xfer cycle=%0d expected xfer=pop+1", pop_c, x_c);
        end
    endtask

    task automatic test_random();
        int d0, d1, budget;
        d0 = del0; d1 = del1; budget = 0;
        for (int i = 0; i < 1500; i++) begin
            src0.push_back(8'($urandom));
            src1.push_back(8'($urandom));
        end
        while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0 && budget < 12000) begin
            rdy         = 1'($urandom_range(0, 1));
            force_empty = ($urandom_range(0, 3) == 0);
            tick();
            budget++;
        end
        force_empty = 1'b0;
        n_tests++;
        if (del0 - d0 != 1500 || del1 - d1 != 1500) begin
            n_fail++;
            $display("FAIL random_count: delivered0=%0d delivered1=%0d expected 1500/1500 (cycles %0d)",
                     del0 - d0, del1 - d1, budget);
        end
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_counter();
        int budget;
        logic [7:0] w;
        budget = 0; w = 8'h00;
        n_tests++;
        if (cnt0_dut !== mcnt0 || cnt1_dut !== mcnt1) begin
            n_fail++;
            $display("FAIL cnt_track: cnt0=%h cnt1=%h expected %h/%h", cnt0_dut, cnt1_dut, mcnt0, mcnt1);
        end
        rdy = 1'b1;
        while (mcnt1 != 16'hFFFF && budget < 70000) begin
            if (src1.size() < 4) begin
                src1.push_back(w);
                w++;
            end
            tick();
            budget++;
        end
        n_tests++;
        if (cnt1_dut !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_preset: rd_word_cnt=%h expected=ffff", cnt1_dut);
        end
        tick();
        n_tests++;
        if (!x1 || cnt1_dut !== 16'h0000) begin
            n_fail++;
            $display("FAIL cnt_wrap: xfer=%b rd_word_cnt=%h expected 1/0000", x1, cnt1_dut);
        end
        repeat (8) tick();
    endtask
`endif

    initial begin
        rd_rst = 1'b1;
        fe0 = 1'b1; fe1 = 1'b1; rdat0 = '0; rdat1 = '0; mr0 = 1'b0; mr1 = 1'b0;
        rdy = 1'b0; force_empty = 1'b0; lat1_data = '0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_boundary();
        test_lat0();
        test_random();
`ifdef FIFO_RD_CNT_EN
        test_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
